rate_detector: RTL
==================

# rate_detector

Receive-side counterpart of the board's rate-divider/display-counter path. Samples a one-cycle enable pulse stream, measures the clock-cycle interval between pulses, and classifies it against the four selectable divider rates. It reports the recovered 2-bit rate code, the raw period, and a 4-bit pulse tally. Used for board self-test and for locking a second board to a remote rate selection.

## Interface
- CNT_W, 28: width of interval counter and `period`.
- RATE0, 1: expected interval (cycles) for code 2'b00.
- RATE1, 50000000: expected interval for code 2'b01.
- RATE2, 100000000: expected interval for code 2'b10.
- RATE3, 200000000: expected interval for code 2'b11.
- TOL, 2: allowed absolute deviation (cycles) for a match.
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- pulse_in  input  1  enable pulse; each high cycle is one pulse.
- rate_code  output  2  last locked rate code.
- rate_valid  output  1  high while locked to a rate.
- period  output  CNT_W  last measured interval in cycles.
- timeout  output  1  no pulse within RATE3+TOL+1 cycles.
- pulse_count  output  4  pulses seen, modulo 16.

## Operation
- Pulse `p` = pulse_in sampled high on a clk edge, after the optional synchronizer.
- Interval counter `cnt`:
  - On p: `cnt <= 1`.
  - Otherwise `cnt <= cnt + 1`, saturating at LIMIT = RATE3+TOL+1.
  - Back-to-back high cycles therefore measure interval 1.
- Match: code k matches when |cnt − RATEk| ≤ TOL.
  - Lowest k wins if ranges overlap.
  - Comparisons are unsigned and carry no wrap, because cnt saturates.
- States are IDLE, ARMED and LOCKED.
  - IDLE: no reference pulse yet. On p go to ARMED; nothing is measured.
  - ARMED, on p:
    - `period <= cnt`.
    - If k matches and `cand == k`: go to LOCKED, `rate_code <= k`, `rate_valid <= 1`.
    - Else if k matches: `cand <= k`, stay ARMED.
    - No match: clear `cand` valid, stay ARMED.
  - LOCKED, on p:
    - `period <= cnt`.
    - Matching the same k: stay LOCKED.
    - Matching a different k: `cand <= k`, go to ARMED, `rate_valid <= 0`; `rate_code` holds.
    - No match: go to ARMED, `rate_valid <= 0`.
  - Any state other than IDLE, when `cnt` reaches LIMIT without p: `timeout <= 1`, `rate_valid <= 0`, go to IDLE.
  - `timeout` clears on the next p.
- Lock therefore needs two consecutive matching intervals of the same code, which is three pulses from IDLE.
- `pulse_count` increments on every p, wraps from 15 to 0, and is independent of state.
- Reset values: `rate_code` 0, `rate_valid` 0, `period` 0, `timeout` 0, `pulse_count` 0, `cnt` 0, state IDLE, `cand` invalid.
- Reset mid-measurement discards the partial interval. The first pulse after reset is a reference pulse only.

## Timing
- All outputs are registered.
- Latency is 1 cycle: p sampled at edge n is reflected in the outputs after edge n.
- `timeout` asserts on the edge where `cnt` reaches LIMIT.
- p and saturation on the same edge: p wins. The interval LIMIT is measured and classified (no match), and `timeout` stays 0.
- reset has priority over p.

## Configuration
- `RATE_DETECTOR_SYNC_EN` defined:
  - pulse_in passes through a 2-flop synchronizer before sampling.
  - Latency becomes 3 cycles.
  - Flops reset to 0.
  - Measured intervals are unchanged.
- Undefined: pulse_in is assumed synchronous to clk and sampled directly.

## Structure
- Package `rate_detector_pkg` holds:
  - the state typedef (IDLE, ARMED, LOCKED);
  - the default RATE0..RATE3, TOL and CNT_W constants;
  - the 2-bit rate-code typedef.
- Sub-module `pulse_sync` is the 2-flop synchronizer, instantiated only under `RATE_DETECTOR_SYNC_EN`.
- Classification is combinational logic inside the top module.

## Test plan
All scenarios use RATE0=1, RATE1=5, RATE2=10, RATE3=20, TOL=1, macro undefined.
- Reset: hold reset 3 cycles with pulse_in toggling -> all outputs 0, state IDLE, `pulse_count` 0.
- Lock code 01: pulses every 5 cycles, 4 pulses -> `rate_valid` rises 1 cycle after the 3rd pulse, `rate_code` 01, `period` 5, `pulse_count` 4.
- Continuous high (code 00): pulse_in held high 4 cycles -> `rate_code` 00, `rate_valid` 1 after the 3rd high cycle, `period` 1.
- Tolerance: intervals 11, 9, 10 -> lock 10 after the 9 interval. Interval 12 -> `rate_valid` drops, `period` 12, `rate_code` holds 10.
- Timeout: locked at 11, then no pulse for 22 cycles -> `timeout` 1 and `rate_valid` 0 exactly 22 cycles after the last pulse. The next pulse clears `timeout` and is a reference only.
- Wrap and reset mid-interval: 17 pulses -> `pulse_count` 1. Reset 3 cycles into an interval, then pulses at intervals 5 and 5 -> lock only after the third post-reset pulse.

Source files
------------

// File: rtl/rate_detector_pkg.sv
// Shared types and default constants for the rate detector.
// Defaults match the board's rate divider settings.
package rate_detector_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   typedef logic [1:0] rate_code_t;

   localparam int DEFAULT_CNT_W = 28;
   localparam int DEFAULT_RATE0 = 1;
   localparam int DEFAULT_RATE1 = 50000000;
   localparam int DEFAULT_RATE2 = 100000000;
   localparam int DEFAULT_RATE3 = 200000000;
   localparam int DEFAULT_TOL   = 2;

   // Evaluated one bit wider so that rate - tol never wraps below zero.
   function automatic logic rate_in_range(input logic [31:0] c,
                                          input logic [31:0] r,
                                          input logic [31:0] t);
      logic [32:0] c_x;
      logic [32:0] r_x;
      logic [32:0] t_x;
      c_x = {1'b0, c};
      r_x = {1'b0, r};
      t_x = {1'b0, t};
      return ((c_x + t_x) >= r_x) && (c_x <= (r_x + t_x));
   endfunction

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchronizer for the incoming pulse stream.
// It is used only when RATE_DETECTOR_SYNC_EN is defined.
module pulse_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rate_detector.sv
// This block measures the interval between enable pulses and locks onto one of four divider rates.
// Define RATE_DETECTOR_SYNC_EN to put a 2-flop synchronizer in front of pulse_in.
module rate_detector
   import rate_detector_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W,
   parameter int RATE0 = DEFAULT_RATE0,
   parameter int RATE1 = DEFAULT_RATE1,
   parameter int RATE2 = DEFAULT_RATE2,
   parameter int RATE3 = DEFAULT_RATE3,
   parameter int TOL   = DEFAULT_TOL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pulse_in,
   output logic [1:0]       rate_code,
   output logic             rate_valid,
   output logic [CNT_W-1:0] period,
   output logic             timeout,
   output logic [3:0]       pulse_count
);

   // The counter saturates one cycle past the slowest acceptable interval.
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(RATE3 + TOL + 1);

   logic             p;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   state_t           state;
   state_t           state_next;
   rate_code_t       cand_code;
   rate_code_t       cand_code_next;
   logic             cand_valid;
   logic             cand_valid_next;
   rate_code_t       rate_code_next;
   logic             rate_valid_next;
   logic [CNT_W-1:0] period_next;
   logic             timeout_next;
   logic [3:0]       pulse_count_next;
   logic [31:0]      cnt_w;
   logic             match_hit;
   rate_code_t       match_code;

`ifdef RATE_DETECTOR_SYNC_EN
   pulse_sync u_pulse_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pulse_in),
      .q     (p)
   );
`else
   assign p = pulse_in;
`endif

   assign cnt_w = 32'(cnt);

   // When several rate windows overlap, the lowest code takes priority.
   always_comb begin
      match_hit  = 1'b1;
      match_code = 2'd0;
      if (rate_in_range(cnt_w, 32'(RATE0), 32'(TOL))) begin
         match_code = 2'd0;
      end else if (rate_in_range(cnt_w, 32'(RATE1), 32'(TOL))) begin
         match_code = 2'd1;
      end else if (rate_in_range(cnt_w, 32'(RATE2), 32'(TOL))) begin
         match_code = 2'd2;
      end else if (rate_in_range(cnt_w, 32'(RATE3), 32'(TOL))) begin
         match_code = 2'd3;
      end else begin
         match_hit  = 1'b0;
      end
   end

   always_comb begin
      state_next       = state;
      cnt_next         = cnt;
      cand_code_next   = cand_code;
      cand_valid_next  = cand_valid;
      rate_code_next   = rate_code;
      rate_valid_next  = rate_valid;
      period_next      = period;
      timeout_next     = timeout;
      pulse_count_next = pulse_count;

      if (p) begin
         cnt_next         = CNT_W'(1);
         pulse_count_next = pulse_count + 4'd1;
         timeout_next     = 1'b0;
         case (state)
            IDLE: begin
               state_next      = ARMED;
               cand_valid_next = 1'b0;
            end
            ARMED: begin
               period_next = cnt;
               if (match_hit && cand_valid && (cand_code == match_code)) begin
                  state_next      = LOCKED;
                  rate_code_next  = match_code;
                  rate_valid_next = 1'b1;
               end else if (match_hit) begin
                  cand_code_next  = match_code;
                  cand_valid_next = 1'b1;
               end else begin
                  cand_valid_next = 1'b0;
               end
            end
            LOCKED: begin
               period_next = cnt;
               if (match_hit && (match_code == rate_code)) begin
                  state_next = LOCKED;
               end else if (match_hit) begin
                  state_next      = ARMED;
                  cand_code_next  = match_code;
                  cand_valid_next = 1'b1;
                  rate_valid_next = 1'b0;
               end else begin
                  state_next      = ARMED;
                  cand_valid_next = 1'b0;
                  rate_valid_next = 1'b0;
               end
            end
            default: begin
               state_next      = IDLE;
               cand_valid_next = 1'b0;
            end
         endcase
      end else begin
         if (cnt != LIMIT) begin
            cnt_next = cnt + CNT_W'(1);
         end
         // A missing pulse for a full LIMIT interval drops the lock.
         if ((state != IDLE) && (cnt == LIMIT)) begin
            state_next      = IDLE;
            timeout_next    = 1'b1;
            rate_valid_next = 1'b0;
            cand_valid_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         cand_code   <= 2'd0;
         cand_valid  <= 1'b0;
         rate_code   <= 2'd0;
         rate_valid  <= 1'b0;
         period      <= '0;
         timeout     <= 1'b0;
         pulse_count <= 4'd0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         cand_code   <= cand_code_next;
         cand_valid  <= cand_valid_next;
         rate_code   <= rate_code_next;
         rate_valid  <= rate_valid_next;
         period      <= period_next;
         timeout     <= timeout_next;
         pulse_count <= pulse_count_next;
      end
   end

endmodule
